// File: rtl/three_pulses_pwm_monitor.sv
// Receive-side checker for the three-pulse PWM drive: measures each half-period of
// the cycle command (length, pulse count, on-time, first-pulse width, polarity).
module three_pulses_pwm_monitor #(
    parameter int CNT_W = 13,
    parameter int PC_W  = 3
) (
    input  logic             clk100MHz,
    input  logic             reset,
    input  logic [1:0]       pwm_drive,
    input  logic             cycle,
    output logic             rpt_valid,
    output logic             rpt_polarity,
    output logic [CNT_W-1:0] rpt_half_period,
    output logic [CNT_W-1:0] rpt_on_time,
    output logic [CNT_W-1:0] rpt_first_width,
    output logic [PC_W-1:0]  rpt_pulse_count,
    output logic             rpt_pol_err,
    output logic             rpt_overflow,
    output logic             shoot_through,
    output logic             cycle_lost
);

    typedef enum logic [1:0] {
        DRV_OFF = 2'b00,
        DRV_NEG = 2'b01,
        DRV_POS = 2'b10,
        DRV_BAD = 2'b11
    } drive_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [PC_W-1:0]  PC_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);

    drive_t           s, s_prev;
    logic             c, c_prev;
    logic             primed;

    logic [CNT_W-1:0] half_cnt, on_cnt, first_w;
    logic [PC_W-1:0]  pulse_cnt;
    logic             first_done, pol_err, ovf;

    logic [CNT_W-1:0] half_nxt, on_nxt, first_nxt;
    logic [PC_W-1:0]  pulse_nxt;
    logic             done_nxt, perr_nxt, ovf_nxt;

    logic active, prev_active, boundary, start, pulse_end, wrong_sign;

    assign active      = (s != DRV_OFF);
    assign prev_active = (s_prev != DRV_OFF);
    assign boundary    = c ^ c_prev;
    assign start       = active & ~prev_active;
    assign pulse_end   = ~active & prev_active;
    // An illegal 11 sample is treated as a pulse of the wrong sign in either half.
    assign wrong_sign  = (s == DRV_BAD) | ((s == DRV_POS) & ~c) | ((s == DRV_NEG) & c);

    assign cycle_lost  = (half_cnt == CNT_MAX);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    always_comb begin
        // NOTE: every next-state variable gets a default first, so no path through this block can infer a latch.
        half_nxt  = half_cnt;
        on_nxt    = on_cnt;
        first_nxt = first_w;
        pulse_nxt = pulse_cnt;
        done_nxt  = first_done;
        perr_nxt  = pol_err;

        if (boundary) begin
            // The boundary sample opens the new window; a pulse in flight restarts as a fresh start.
            half_nxt  = CNT_ONE;
            on_nxt    = {{(CNT_W-1){1'b0}}, active};
            first_nxt = {{(CNT_W-1){1'b0}}, active};
            pulse_nxt = {{(PC_W-1){1'b0}}, active};
            done_nxt  = 1'b0;
            perr_nxt  = wrong_sign;
        end else begin
            half_nxt = sat_inc(half_cnt);
            if (active) begin
                on_nxt = sat_inc(on_cnt);
            end
            if (active && !first_done) begin
                first_nxt = sat_inc(first_w);
            end
            if (start && pulse_cnt != PC_MAX) begin
                pulse_nxt = pulse_cnt + PC_ONE;
            end
            done_nxt = first_done | pulse_end;
            perr_nxt = pol_err | wrong_sign;
        end

        ovf_nxt = (ovf & ~boundary) | (half_nxt == CNT_MAX) | (on_nxt == CNT_MAX)
                | (first_nxt == CNT_MAX) | (pulse_nxt == PC_MAX);
    end

    always_ff @(posedge clk100MHz) begin
        // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            // Loading the history registers from the live inputs suppresses a false first boundary.
            s               <= drive_t'(pwm_drive);
            s_prev          <= drive_t'(pwm_drive);
            c               <= cycle;
            c_prev          <= cycle;
            primed          <= 1'b0;
            half_cnt        <= '0;
            on_cnt          <= '0;
            first_w         <= '0;
            pulse_cnt       <= '0;
            first_done      <= 1'b0;
            pol_err         <= 1'b0;
            ovf             <= 1'b0;
            shoot_through   <= 1'b0;
            rpt_valid       <= 1'b0;
            rpt_polarity    <= 1'b0;
            rpt_half_period <= '0;
            rpt_on_time     <= '0;
            rpt_first_width <= '0;
            rpt_pulse_count <= '0;
            rpt_pol_err     <= 1'b0;
            rpt_overflow    <= 1'b0;
        end else begin
            s             <= drive_t'(pwm_drive);
            s_prev        <= s;
            c             <= cycle;
            c_prev        <= c;
            half_cnt      <= half_nxt;
            on_cnt        <= on_nxt;
            first_w       <= first_nxt;
            pulse_cnt     <= pulse_nxt;
            first_done    <= done_nxt;
            pol_err       <= perr_nxt;
            ovf           <= ovf_nxt;
            shoot_through <= shoot_through | (s == DRV_BAD);
            rpt_valid     <= boundary & primed;

            // The first window after reset is partial, so its boundary only arms reporting.
            if (boundary) begin
                primed <= 1'b1;
                if (primed) begin
                    rpt_polarity    <= c_prev;
                    rpt_half_period <= half_cnt;
                    rpt_on_time     <= on_cnt;
                    rpt_first_width <= first_w;
                    rpt_pulse_count <= pulse_cnt;
                    rpt_pol_err     <= pol_err;
                    rpt_overflow    <= ovf;
                end
            end
        end
    end

endmodule
